// File: rtl/rnn_pkg.sv
// rtl/rnn_pkg.sv - shared states, RNN core register map and parameter defaults
package rnn_pkg;

  localparam int DEF_EMB_BITS   = 2;
  localparam int DEF_CHAR_BITS  = 6;
  localparam int DEF_FIFO_BITS  = 4;
  localparam int DEF_POLL_LIMIT = 4095;

  // write-side and read-side views of the core register map share addresses
  localparam logic [2:0] REG_START  = 3'd0;
  localparam logic [2:0] REG_INPUT  = 3'd1;
  localparam logic [2:0] REG_DENSE  = 3'd7;
  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_READY  = 3'd1;
  localparam logic [2:0] REG_RESULT = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WR_EMB,
    ST_START,
    ST_POLL_LOAD,
    ST_DENSE,
    ST_POLL_VALID,
    ST_READ_RES,
    ST_OUT
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO, combinational read of the head entry
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]    mem [2**DEPTH_BITS];
  logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
  logic                do_push, do_pop;

  // extra pointer bit separates full from empty when the indices match
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                   (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q[DEPTH_BITS-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[DEPTH_BITS-1:0]] <= din;
  end

endmodule

// File: rtl/rnn_seq_feeder.sv
// rtl/rnn_seq_feeder.sv - feeds buffered characters as embeddings into an RNN core
// and returns the dense-layer result once a sequence ends.
module rnn_seq_feeder
  import rnn_pkg::*;
#(
  parameter int EMB_BITS   = DEF_EMB_BITS,
  parameter int CHAR_BITS  = DEF_CHAR_BITS,
  parameter int FIFO_BITS  = DEF_FIFO_BITS,
  parameter int POLL_LIMIT = DEF_POLL_LIMIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          char_valid,
  input  logic [CHAR_BITS-1:0]          char_data,
  input  logic                          char_last,
  output logic                          char_ready,
  input  logic                          emb_write,
  input  logic [CHAR_BITS+EMB_BITS-1:0] emb_addr,
  input  logic [15:0]                   emb_data,
  output logic                          m_read,
  output logic                          m_write,
  output logic [2:0]                    m_addr,
  output logic [31:0]                   m_wdata,
  input  logic [31:0]                   m_rdata,
  output logic                          res_valid,
  output logic [15:0]                   res_data,
  input  logic                          res_ready,
  output logic                          busy,
  output logic                          err
);

  localparam int AW  = CHAR_BITS + EMB_BITS;
  localparam int PCW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  state_t                 state_q, state_d;
  logic [CHAR_BITS-1:0]   char_q, char_d;
  logic                   last_q, last_d;
  logic [EMB_BITS-1:0]    emb_k_q, emb_k_d, emb_k_nxt;
  logic [PCW-1:0]         poll_cnt_q, poll_cnt_d;
  logic                   err_q, err_d;
  logic [15:0]            res_data_q, res_data_d;

  logic [15:0]            emb_mem [2**AW];
  logic [15:0]            emb_q;
  logic [AW-1:0]          emb_raddr;

  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [CHAR_BITS:0]     fifo_dout;
  logic                   poll_timeout;
  logic                   unused_rdata;

  sync_fifo #(
    .WIDTH      (CHAR_BITS + 1),
    .DEPTH_BITS (FIFO_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (char_valid),
    .din   ({char_last, char_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign char_ready   = !fifo_full;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign err          = err_q;
  assign res_data     = res_data_q;
  assign emb_k_nxt    = emb_k_q + 1'b1;
  assign poll_timeout = (poll_cnt_q == PCW'(POLL_LIMIT - 1));
  assign unused_rdata = ^m_rdata[31:16];

  always_comb begin
    state_d    = state_q;
    char_d     = char_q;
    last_d     = last_q;
    emb_k_d    = emb_k_q;
    poll_cnt_d = '0;
    err_d      = err_q;
    res_data_d = res_data_q;
    emb_raddr  = {char_q, emb_k_nxt};
    fifo_pop   = 1'b0;
    m_read     = 1'b0;
    m_write    = 1'b0;
    m_addr     = 3'd0;
    m_wdata    = 32'd0;
    res_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        fifo_pop  = 1'b1;
        char_d    = fifo_dout[CHAR_BITS-1:0];
        last_d    = fifo_dout[CHAR_BITS];
        emb_raddr = {fifo_dout[CHAR_BITS-1:0], {EMB_BITS{1'b0}}};
        emb_k_d   = '0;
        state_d   = ST_WR_EMB;
      end
      ST_WR_EMB: begin
        // emb_q holds element k while element k+1 is being fetched
        m_write = 1'b1;
        m_addr  = REG_INPUT;
        m_wdata = {8'h00, 8'(emb_k_q), emb_q};
        emb_k_d = emb_k_nxt;
        if (emb_k_q == {EMB_BITS{1'b1}}) state_d = ST_START;
      end
      ST_START: begin
        m_write = 1'b1;
        m_addr  = REG_START;
        state_d = ST_POLL_LOAD;
      end
      ST_POLL_LOAD: begin
        m_read = 1'b1;
        m_addr = REG_READY;
        if (m_rdata[0]) begin
          state_d = last_q ? ST_DENSE : ST_IDLE;
        end else if (poll_timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      ST_DENSE: begin
        m_write = 1'b1;
        m_addr  = REG_DENSE;
        state_d = ST_POLL_VALID;
      end
      ST_POLL_VALID: begin
        m_read = 1'b1;
        m_addr = REG_STATUS;
        if (m_rdata[0]) begin
          state_d = ST_READ_RES;
        end else if (poll_timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      ST_READ_RES: begin
        m_read     = 1'b1;
        m_addr     = REG_RESULT;
        res_data_d = m_rdata[15:0];
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      char_q     <= '0;
      last_q     <= 1'b0;
      emb_k_q    <= '0;
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      char_q     <= char_d;
      last_q     <= last_d;
      emb_k_q    <= emb_k_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
      res_data_q <= res_data_d;
    end
  end

  // table keeps its contents across reset; host updates only while idle
  always_ff @(posedge clk) begin
    if (emb_write && !busy) emb_mem[emb_addr] <= emb_data;
    emb_q <= emb_mem[emb_raddr];
  end

endmodule

// File: doc/rnn_seq_feeder.md
RNN_SEQ_FEEDER -- requirements
Module: rnn_seq_feeder

Interface
REQ-001 SHALL have parameter EMB_BITS, default 2, log2 of embedding elements per character; must equal the RNN core's embedding width.
REQ-002 SHALL have parameter CHAR_BITS, default 6, log2 of vocabulary size.
REQ-003 SHALL have parameter FIFO_BITS, default 4, log2 of character FIFO depth.
REQ-004 SHALL have parameter POLL_LIMIT, default 4095, maximum poll cycles before error.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 char_valid  in  1  host offers a character.
REQ-008 char_data  in  CHAR_BITS  character code.
REQ-009 char_last  in  1  offered character ends the sequence.
REQ-010 char_ready  out  1  FIFO not full.
REQ-011 emb_write  in  1  embedding table write strobe.
REQ-012 emb_addr  in  CHAR_BITS+EMB_BITS  {char, element} table address.
REQ-013 emb_data  in  16  table entry, Q8.8 signed.
REQ-014 m_read / m_write  out  1 each  RNN core slave strobes.
REQ-015 m_addr  out  3  RNN core register address.
REQ-016 m_wdata  out  32  RNN core write data.
REQ-017 m_rdata  in  32  RNN core read data, combinational in the same cycle as m_read.
REQ-018 res_valid  out  1  result held.
REQ-019 res_data  out  16  dense-layer result.
REQ-020 res_ready  in  1  consumer takes result.
REQ-021 busy  out  1  state not IDLE or FIFO not empty.
REQ-022 err  out  1  sticky poll-timeout flag.

Function
REQ-023 FIFO SHALL store {char_last, char_data}; push on char_valid&&char_ready; no bypass; char_ready depends only on the full flag, so a simultaneous push and pop when full is refused.
REQ-024 Embedding RAM SHALL be 2^(CHAR_BITS+EMB_BITS) x 16 with 1-cycle registered read; writes are honoured only while busy=0 and ignored otherwise.
REQ-025 FSM states SHALL be IDLE, FETCH, WR_EMB, START, POLL_LOAD, DENSE, POLL_VALID, READ_RES, OUT.
REQ-026 IDLE->FETCH when FIFO not empty; FETCH pops one entry, latches char/last, and issues the RAM read of element 0.
REQ-027 WR_EMB SHALL run 2^EMB_BITS consecutive cycles; cycle k drives m_write=1, m_addr=1, m_wdata={8'h00, k[7:0], ram_q}, and reads element k+1 in the same cycle.
REQ-028 START SHALL drive one cycle of m_write=1, m_addr=0, m_wdata=0.
REQ-029 POLL_LOAD SHALL drive m_read=1, m_addr=1 each cycle and exit when m_rdata[0]=1: to DENSE if latched last=1, else to IDLE.
REQ-030 DENSE SHALL drive one cycle of m_write=1, m_addr=7; POLL_VALID reads addr 0 until m_rdata[0]=1.
REQ-031 READ_RES SHALL drive m_read=1, m_addr=7 for exactly one cycle, capture m_rdata[15:0] into res_data, then go to OUT.
REQ-032 OUT SHALL hold res_valid=1 and res_data stable until res_ready=1, then return to IDLE; the FIFO keeps accepting pushes meanwhile.
REQ-033 At most one of m_read/m_write SHALL be high in any cycle; m_addr and m_wdata SHALL be 0 when both are low.
REQ-034 Each poll state SHALL count cycles; reaching POLL_LIMIT sets err=1 and forces IDLE; err clears only on rst.
REQ-035 Latency: a push into an empty idle block at edge t SHALL produce the first m_write at cycle t+3 and the START write at t+3+2^EMB_BITS.

Reset
REQ-036 rst SHALL force state IDLE, FIFO empty, err=0, res_valid=0, res_data=0, all m_* outputs 0, and busy=0 on the next edge, including mid-sequence.
REQ-037 Embedding RAM contents SHALL NOT be reset.

Structure
REQ-038 The state enum, register addresses (START=0, INPUT=1, DENSE=7, STATUS=0, READY=1, RESULT=7), and parameter defaults SHALL live in shared package rnn_pkg.
REQ-039 The FIFO SHALL be sub-module sync_fifo, parameterised by width and depth bits.

Verification
REQ-040 Load emb[5][0..3]=0x0100,0x0200,0x0300,0x0400; push char 5 with last=0 -> writes addr1 with data 0x00000100, 0x00010200, 0x00020300, 0x00030400, then one addr0 write; after READY=1 -> IDLE.
REQ-041 Sequence 3,7,9 with last on 9 -> three embed/start rounds, one addr7 write; model returns 0x0123 -> res_valid=1, res_data=0x0123 held for 5 cycles of res_ready=0.
REQ-042 Push 16 chars with the core stalled -> char_ready=0 after the 16th push; a 17th push is not accepted; draining processes exactly 16 characters in order.
REQ-043 Core model never returns READY=1 -> err=1 after POLL_LIMIT cycles, state IDLE; a new char is then processed.
REQ-044 Assert rst during WR_EMB element 2 -> next cycle all m_* outputs 0 and busy=0; emb table still returns loaded values afterwards.
REQ-045 emb_write while busy=1 -> table entry unchanged.
